wb_stage_dual: RTL and testbench

//  Dual-issue write-back stage, directly upstream of the 2-write/4-read register file.

---
 rtl/wb_stage_dual_pkg.sv | 20 ++
 rtl/wb_stage_dual_trace_mux.sv | 54 +++++
 rtl/wb_stage_dual.sv | 137 +++++++++++++
 tb/tb_wb_stage_dual.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_dual_pkg.sv
// Shared definitions for the dual-issue write-back stage: FSM encodings,
// default lane field widths and the packed width of one memory-to-WB lane.
package wb_stage_dual_pkg;

    typedef enum logic [1:0] {
        WB_ST_EMPTY = 2'd0,
        WB_ST_EMIT1 = 2'd1,
        WB_ST_EMIT2 = 2'd2
    } wb_state_e;

    localparam int LANE_ADDR_W = 5;
    localparam int LANE_DATA_W = 32;
    localparam int LANE_PC_W   = 32;

    // One lane packs as {valid, pc, we, waddr, wdata}.
    function automatic int ms_to_ws_bus_width(input int pc_w, input int addr_w, input int data_w);
        return 2 + pc_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/wb_stage_dual_trace_mux.sv
// Combinational lane select for the single difftest trace port, plus the
// trace field formatting (byte enables expanded from the lane write flag).
module wb_trace_mux
    import wb_stage_dual_pkg::*;
#(
    parameter int ADDR_W = LANE_ADDR_W,
    parameter int DATA_W = LANE_DATA_W,
    parameter int PC_W   = LANE_PC_W
) (
    input  wb_state_e          state,
    input  logic               lane_valid [2],
    input  logic [PC_W-1:0]    lane_pc    [2],
    input  logic               lane_we    [2],
    input  logic [ADDR_W-1:0]  lane_waddr [2],
    input  logic [DATA_W-1:0]  lane_wdata [2],
    output logic [PC_W-1:0]    debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [ADDR_W-1:0]  debug_wb_rf_wnum,
    output logic [DATA_W-1:0]  debug_wb_rf_wdata
);

    logic show;
    logic sel;

    always_comb begin
        show = 1'b0;
        sel  = 1'b0;
        case (state)
            WB_ST_EMIT1: begin
                show = 1'b1;
                sel  = !lane_valid[0];
            end
            WB_ST_EMIT2: begin
                show = 1'b1;
                sel  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        debug_wb_pc       = '0;
        debug_wb_rf_we    = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (show) begin
            debug_wb_pc       = lane_pc[sel];
            debug_wb_rf_we    = {4{lane_we[sel] & (lane_waddr[sel] != '0)}};
            debug_wb_rf_wnum  = lane_waddr[sel];
            debug_wb_rf_wdata = lane_wdata[sel];
        end
    end

endmodule

// File: rtl/wb_stage_dual.sv
// Dual-issue write-back stage: latches a two-lane bundle, writes both RF ports
// in the first cycle, and serialises the retired lanes onto one trace port.
module wb_stage_dual
    import wb_stage_dual_pkg::*;
#(
    parameter int ADDR_W = LANE_ADDR_W,
    parameter int DATA_W = LANE_DATA_W,
    parameter int PC_W   = LANE_PC_W
) (
    input  logic               wb_in_clk,
    input  logic               wb_in_rst,
    input  logic               ms_to_ws_valid,
    output logic               ws_allowin,
    input  logic               l1_valid,
    input  logic [PC_W-1:0]    l1_pc,
    input  logic               l1_we,
    input  logic [ADDR_W-1:0]  l1_waddr,
    input  logic [DATA_W-1:0]  l1_wdata,
    input  logic               l2_valid,
    input  logic [PC_W-1:0]    l2_pc,
    input  logic               l2_we,
    input  logic [ADDR_W-1:0]  l2_waddr,
    input  logic [DATA_W-1:0]  l2_wdata,
    output logic               rf_we1,
    output logic [ADDR_W-1:0]  rf_waddr1,
    output logic [DATA_W-1:0]  rf_wdata1,
    output logic               rf_we2,
    output logic [ADDR_W-1:0]  rf_waddr2,
    output logic [DATA_W-1:0]  rf_wdata2,
    output logic [PC_W-1:0]    debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [ADDR_W-1:0]  debug_wb_rf_wnum,
    output logic [DATA_W-1:0]  debug_wb_rf_wdata
);

    localparam int LANE_W = ms_to_ws_bus_width(PC_W, ADDR_W, DATA_W);

    wb_state_e state_reg;
    wb_state_e state_next;

    logic [LANE_W-1:0] lane_in    [2];
    logic [LANE_W-1:0] bundle_reg [2];

    logic              b_valid [2];
    logic [PC_W-1:0]   b_pc    [2];
    logic              b_we    [2];
    logic [ADDR_W-1:0] b_waddr [2];
    logic [DATA_W-1:0] b_wdata [2];
    logic              b_wr    [2];

    logic accept;
    logic any_valid_in;

    assign lane_in[0] = {l1_valid, l1_pc, l1_we, l1_waddr, l1_wdata};
    assign lane_in[1] = {l2_valid, l2_pc, l2_we, l2_waddr, l2_wdata};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            always_ff @(posedge wb_in_clk or posedge wb_in_rst) begin
                if (wb_in_rst) begin
                    bundle_reg[gi] <= '0;
                end else if (accept) begin
                    bundle_reg[gi] <= lane_in[gi];
                end
            end

            assign b_valid[gi] = bundle_reg[gi][LANE_W-1];
            assign b_pc[gi]    = bundle_reg[gi][LANE_W-2 -: PC_W];
            assign b_we[gi]    = bundle_reg[gi][ADDR_W+DATA_W];
            assign b_waddr[gi] = bundle_reg[gi][ADDR_W+DATA_W-1 -: ADDR_W];
            assign b_wdata[gi] = bundle_reg[gi][DATA_W-1:0];
            // r0 is hardwired zero, so a write to it is never issued.
            assign b_wr[gi]    = b_valid[gi] & b_we[gi] & (b_waddr[gi] != '0);
        end
    endgenerate

    assign ws_allowin = (state_reg == WB_ST_EMPTY)
                      | ((state_reg == WB_ST_EMIT1) & !(b_valid[0] & b_valid[1]))
                      | (state_reg == WB_ST_EMIT2);

    assign accept       = ms_to_ws_valid & ws_allowin;
    assign any_valid_in = l1_valid | l2_valid;

    always_ff @(posedge wb_in_clk or posedge wb_in_rst) begin
        if (wb_in_rst) begin
            state_reg <= WB_ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // An accepted bundle with no valid lane is dropped without ever reaching EMIT1.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WB_ST_EMIT1: begin
                if (b_valid[0] & b_valid[1]) begin
                    state_next = WB_ST_EMIT2;
                end else if (accept & any_valid_in) begin
                    state_next = WB_ST_EMIT1;
                end else begin
                    state_next = WB_ST_EMPTY;
                end
            end
            WB_ST_EMPTY, WB_ST_EMIT2: begin
                state_next = (accept & any_valid_in) ? WB_ST_EMIT1 : WB_ST_EMPTY;
            end
            default: state_next = WB_ST_EMPTY;
        endcase
    end

    // Same-destination writes are passed through untouched; the RF resolves them.
    assign rf_we1    = (state_reg == WB_ST_EMIT1) & b_wr[0];
    assign rf_waddr1 = b_waddr[0];
    assign rf_wdata1 = b_wdata[0];
    assign rf_we2    = (state_reg == WB_ST_EMIT1) & b_wr[1];
    assign rf_waddr2 = b_waddr[1];
    assign rf_wdata2 = b_wdata[1];

    wb_trace_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_trace_mux (
        .state             (state_reg),
        .lane_valid        (b_valid),
        .lane_pc           (b_pc),
        .lane_we           (b_we),
        .lane_waddr        (b_waddr),
        .lane_wdata        (b_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

endmodule

// File: tb/tb_wb_stage_dual.sv
// Bench for wb_stage_dual: hand-derived vector table, async-reset sequence and
// random traffic checked against a queue-based model of retiring lanes.
module tb_wb_stage_dual;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } lane_t;

    typedef struct packed {
        logic        allowin;
        logic        we1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        we2;
        logic [4:0]  a2;
        logic [31:0] d2;
        logic [31:0] pc;
        logic [3:0]  dwe;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } out_t;

    typedef struct packed {
        logic  msv;
        lane_t l1;
        lane_t l2;
        out_t  exp;
    } vec_t;

    logic clk;
    logic rst;
    logic msv_s;
    lane_t l1_s;
    lane_t l2_s;

    logic        ws_allowin;
    logic        rf_we1, rf_we2;
    logic [4:0]  rf_waddr1, rf_waddr2;
    logic [31:0] rf_wdata1, rf_wdata2;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int vectors;
    int miscompares;

    wb_stage_dual dut (
        .wb_in_clk         (clk),
        .wb_in_rst         (rst),
        .ms_to_ws_valid    (msv_s),
        .ws_allowin        (ws_allowin),
        .l1_valid          (l1_s.valid),
        .l1_pc             (l1_s.pc),
        .l1_we             (l1_s.we),
        .l1_waddr          (l1_s.waddr),
        .l1_wdata          (l1_s.wdata),
        .l2_valid          (l2_s.valid),
        .l2_pc             (l2_s.pc),
        .l2_we             (l2_s.we),
        .l2_waddr          (l2_s.waddr),
        .l2_wdata          (l2_s.wdata),
        .rf_we1            (rf_we1),
        .rf_waddr1         (rf_waddr1),
        .rf_wdata1         (rf_wdata1),
        .rf_we2            (rf_we2),
        .rf_waddr2         (rf_waddr2),
        .rf_wdata2         (rf_wdata2),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register file: port 2 is written last, so it wins on a shared address.
    logic [31:0] tb_rf [32];
    always @(posedge clk) begin
        if (rf_we1) tb_rf[rf_waddr1] <= rf_wdata1;
        if (rf_we2) tb_rf[rf_waddr2] <= rf_wdata2;
    end

    // Model: the lanes still owed to the trace port, oldest first.
    lane_t pend[$];
    bit    first;
    lane_t mb1, mb2;

    function automatic lane_t mk_lane(input logic v, input logic [31:0] pc, input logic we,
                                      input logic [4:0] a, input logic [31:0] d);
        lane_t l;
        l.valid = v; l.pc = pc; l.we = we; l.waddr = a; l.wdata = d;
        return l;
    endfunction

    function automatic out_t mk_out(input logic al, input logic w1, input logic [4:0] a1,
                                    input logic [31:0] d1, input logic w2, input logic [4:0] a2,
                                    input logic [31:0] d2, input logic [31:0] pc, input logic [3:0] dwe,
                                    input logic [4:0] wn, input logic [31:0] wd);
        out_t o;
        o.allowin = al; o.we1 = w1; o.a1 = a1; o.d1 = d1; o.we2 = w2; o.a2 = a2; o.d2 = d2;
        o.pc = pc; o.dwe = dwe; o.wnum = wn; o.wdata = wd;
        return o;
    endfunction

    function automatic out_t model_out();
        out_t o;
        o = '0;
        o.allowin = (pend.size() <= 1);
        if (pend.size() > 0) begin
            if (first) begin
                o.we1 = mb1.valid && mb1.we && (mb1.waddr != 0);
                o.a1  = mb1.waddr;
                o.d1  = mb1.wdata;
                o.we2 = mb2.valid && mb2.we && (mb2.waddr != 0);
                o.a2  = mb2.waddr;
                o.d2  = mb2.wdata;
            end
            o.pc    = pend[0].pc;
            o.dwe   = (pend[0].we && pend[0].waddr != 0) ? 4'hf : 4'h0;
            o.wnum  = pend[0].waddr;
            o.wdata = pend[0].wdata;
        end
        return o;
    endfunction

    task automatic model_reset();
        pend.delete();
        first = 0;
        mb1 = '0;
        mb2 = '0;
    endtask

    task automatic model_edge(input logic msv, input lane_t l1, input lane_t l2, input logic allow);
        lane_t dummy;
        if (pend.size() > 0) begin
            dummy = pend.pop_front();
            first = 0;
        end
        if (msv && allow) begin
            first = 1;
            mb1 = l1;
            mb2 = l2;
            if (l1.valid) pend.push_back(l1);
            if (l2.valid) pend.push_back(l2);
        end
    endtask

    task automatic check(input string name, input out_t e, input bit all);
        out_t a;
        bit bad;
        a.allowin = ws_allowin; a.we1 = rf_we1; a.a1 = rf_waddr1; a.d1 = rf_wdata1;
        a.we2 = rf_we2; a.a2 = rf_waddr2; a.d2 = rf_wdata2; a.pc = debug_wb_pc;
        a.dwe = debug_wb_rf_we; a.wnum = debug_wb_rf_wnum; a.wdata = debug_wb_rf_wdata;
        bad = (a.allowin !== e.allowin) || (a.we1 !== e.we1) || (a.we2 !== e.we2) ||
              (a.pc !== e.pc) || (a.dwe !== e.dwe) || (a.wnum !== e.wnum) || (a.wdata !== e.wdata);
        if (all || e.we1) bad = bad || (a.a1 !== e.a1) || (a.d1 !== e.d1);
        if (all || e.we2) bad = bad || (a.a2 !== e.a2) || (a.d2 !== e.d2);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got al=%0b rf1=%0b/%0d/%h rf2=%0b/%0d/%h tr=%h/%h/%0d/%h, need al=%0b rf1=%0b/%0d/%h rf2=%0b/%0d/%h tr=%h/%h/%0d/%h",
                     name, a.allowin, a.we1, a.a1, a.d1, a.we2, a.a2, a.d2, a.pc, a.dwe, a.wnum, a.wdata,
                     e.allowin, e.we1, e.a1, e.d1, e.we2, e.a2, e.d2, e.pc, e.dwe, e.wnum, e.wdata);
        end
    endtask

    // One cycle: drive inputs, check against the model (and the table row if given), clock.
    task automatic step(input string name, input logic msv, input lane_t l1, input lane_t l2,
                        input bit has_tbl, input out_t texp);
        out_t e;
        msv_s = msv;
        l1_s  = l1;
        l2_s  = l2;
        #1;
        e = model_out();
        check({name, "_model"}, e, 1'b0);
        if (has_tbl) check({name, "_table"}, texp, 1'b0);
        $display("step %s: msv=%0b v=%0b%0b allowin=%0b rf_we=%0b%0b trace pc=%h we=%h wnum=%0d wdata=%h",
                 name, msv, l1.valid, l2.valid, ws_allowin, rf_we1, rf_we2,
                 debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata);
        @(posedge clk);
        model_edge(msv, l1, l2, e.allowin);
        #1;
    endtask

    vec_t  tbl [10];
    lane_t nil;
    out_t  idle;
    out_t  zero_out;

    initial begin
        vectors     = 0;
        miscompares = 0;
        nil  = mk_lane(0, 0, 0, 0, 0);
        idle = mk_out(1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        zero_out = idle;
        model_reset();
        for (int i = 0; i < 32; i++) tb_rf[i] = '0;

        tbl[0] = '{1'b0, nil, nil, idle};
        tbl[1] = '{1'b1, mk_lane(1, 32'h1c000000, 1, 5, 32'h1234), nil, idle};
        tbl[2] = '{1'b1, mk_lane(1, 32'h1c000004, 1, 3, 32'hA), mk_lane(1, 32'h1c000008, 1, 4, 32'hB),
                   mk_out(1, 1, 5, 32'h1234, 0, 0, 0, 32'h1c000000, 4'hf, 5, 32'h1234)};
        tbl[3] = '{1'b0, nil, nil,
                   mk_out(0, 1, 3, 32'hA, 1, 4, 32'hB, 32'h1c000004, 4'hf, 3, 32'hA)};
        tbl[4] = '{1'b1, mk_lane(1, 32'h1c00000c, 1, 7, 32'h1), mk_lane(1, 32'h1c000010, 1, 7, 32'h2),
                   mk_out(1, 0, 0, 0, 0, 0, 0, 32'h1c000008, 4'hf, 4, 32'hB)};
        tbl[5] = '{1'b0, nil, nil,
                   mk_out(0, 1, 7, 32'h1, 1, 7, 32'h2, 32'h1c00000c, 4'hf, 7, 32'h1)};
        tbl[6] = '{1'b1, mk_lane(1, 32'h1c000014, 1, 0, 32'h55), nil,
                   mk_out(1, 0, 0, 0, 0, 0, 0, 32'h1c000010, 4'hf, 7, 32'h2)};
        tbl[7] = '{1'b1, nil, mk_lane(1, 32'h1c000018, 1, 9, 32'h99),
                   mk_out(1, 0, 0, 0, 0, 0, 0, 32'h1c000014, 4'h0, 0, 32'h55)};
        tbl[8] = '{1'b1, nil, nil,
                   mk_out(1, 0, 0, 0, 1, 9, 32'h99, 32'h1c000018, 4'hf, 9, 32'h99)};
        tbl[9] = '{1'b0, nil, nil, idle};

        rst   = 1'b1;
        msv_s = 1'b0;
        l1_s  = nil;
        l2_s  = nil;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", zero_out, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].msv, tbl[i].l1, tbl[i].l2, 1'b1, tbl[i].exp);
        end

        vectors++;
        if (tb_rf[7] !== 32'h2) begin
            miscompares++;
            $display("FAIL same_dest_r7: got %h need %h", tb_rf[7], 32'h2);
        end

        // Async reset while the second lane of a dual bundle is being traced.
        step("ar_acc", 1'b1, mk_lane(1, 32'h2000, 1, 10, 32'hAA), mk_lane(1, 32'h2004, 1, 11, 32'hBB), 1'b1,
             idle);
        step("ar_emit1", 1'b0, nil, nil, 1'b1,
             mk_out(0, 1, 10, 32'hAA, 1, 11, 32'hBB, 32'h2000, 4'hf, 10, 32'hAA));
        #1;
        check("ar_emit2", mk_out(1, 0, 0, 0, 0, 0, 0, 32'h2004, 4'hf, 11, 32'hBB), 1'b0);
        #1 rst = 1'b1;
        #1;
        check("ar_async_zero", zero_out, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        check("ar_held", zero_out, 1'b1);
        rst = 1'b0;
        step("ar_next_acc", 1'b1, mk_lane(1, 32'h3000, 1, 12, 32'hCC), nil, 1'b1, idle);
        step("ar_next_emit", 1'b0, nil, nil, 1'b1,
             mk_out(1, 1, 12, 32'hCC, 0, 0, 0, 32'h3000, 4'hf, 12, 32'hCC));
        step("ar_idle", 1'b0, nil, nil, 1'b1, idle);

        for (int i = 0; i < 400; i++) begin
            lane_t r1, r2;
            r1 = mk_lane(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 7)), $urandom);
            r2 = mk_lane(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 7)), $urandom);
            step($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0), r1, r2, 1'b0, idle);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
